// File: rtl/sdram_port_arbiter.sv
// Two-port (CPU, tester) arbiter feeding one SDRAM controller slot stream.
// CPU has priority; a tester request that loses MAX_WAIT slots is forced through.
module sdram_port_arbiter #(
  parameter int RD_DELAY = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_slot_stb,
  input  logic [15:0] i_mem_dout,
  output logic [20:0] o_mem_addr,
  output logic [7:0]  o_mem_din,
  output logic        o_mem_we,
  output logic        o_mem_aux,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [20:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_din,
  input  logic        i_cpu_aux,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_dout,
  input  logic        i_tst_req,
  input  logic        i_tst_we,
  input  logic [20:0] i_tst_addr,
  input  logic [7:0]  i_tst_din,
  input  logic        i_tst_aux,
  output logic        o_tst_ack,
  output logic [7:0]  o_tst_dout,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [3:0] DLY_INIT = 4'(RD_DELAY - 1);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [20:0] r_mem_addr;
  logic [7:0]  r_mem_din;
  logic        r_mem_we;
  logic        r_mem_aux;
  logic        r_cpu_ack;
  logic        r_tst_ack;
  logic [7:0]  r_cpu_dout;
  logic [7:0]  r_tst_dout;
  logic        r_busy;
  logic        r_err;
  logic        r_own;      // 1: tester owns the in-flight transfer
  logic [3:0]  r_wait;
  logic [3:0]  r_dly;

  logic        w_arb;
  logic        w_tst_force;
  logic        w_gnt_cpu;
  logic        w_gnt_tst;
  logic [7:0]  w_rd_byte;

  always_comb begin
    w_arb       = i_slot_stb & ~r_busy;
    w_tst_force = i_tst_req & (r_wait == WAIT_MAX);
    w_gnt_cpu   = w_arb & i_cpu_req & ~w_tst_force;
    w_gnt_tst   = w_arb & i_tst_req & (w_tst_force | ~i_cpu_req);
    w_rd_byte   = r_mem_aux ? i_mem_dout[15:8] : i_mem_dout[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_we   <= 1'b0;
      r_mem_aux  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_tst_ack  <= 1'b0;
      r_cpu_dout <= '0;
      r_tst_dout <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_own      <= 1'b0;
      r_wait     <= '0;
      r_dly      <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_tst_ack <= 1'b0;
      if (i_slot_stb && r_busy)
        r_err <= 1'b1;
      if (w_arb) begin
        if (w_gnt_tst || !i_tst_req)
          r_wait <= '0;
        else if (r_wait != WAIT_MAX)
          r_wait <= r_wait + 4'd1;
        if (w_gnt_cpu || w_gnt_tst) begin
          r_mem_addr <= w_gnt_tst ? i_tst_addr : i_cpu_addr;
          r_mem_din  <= w_gnt_tst ? i_tst_din  : i_cpu_din;
          r_mem_aux  <= w_gnt_tst ? i_tst_aux  : i_cpu_aux;
          r_mem_we   <= w_gnt_tst ? i_tst_we   : i_cpu_we;
          r_own      <= w_gnt_tst;
          r_busy     <= 1'b1;
          r_dly      <= DLY_INIT;
        end else begin
          r_mem_we <= 1'b0;
        end
      end else if (r_busy) begin
        if (r_dly == 4'd1) begin
          // Completion: drop we so the controller cannot replay the write.
          r_busy   <= 1'b0;
          r_mem_we <= 1'b0;
          r_dly    <= '0;
          if (r_own) begin
            r_tst_ack <= 1'b1;
            if (!r_mem_we) r_tst_dout <= w_rd_byte;
          end else begin
            r_cpu_ack <= 1'b1;
            if (!r_mem_we) r_cpu_dout <= w_rd_byte;
          end
        end else begin
          r_dly <= r_dly - 4'd1;
        end
      end
    end
  end

  assign o_mem_addr = r_mem_addr;
  assign o_mem_din  = r_mem_din;
  assign o_mem_we   = r_mem_we;
  assign o_mem_aux  = r_mem_aux;
  assign o_cpu_ack  = r_cpu_ack;
  assign o_tst_ack  = r_tst_ack;
  assign o_cpu_dout = r_cpu_dout;
  assign o_tst_dout = r_tst_dout;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: stimulus pushes expected acks into a scoreboard, a negedge monitor checks them.
module tb_sdram_port_arbiter;
  localparam int RD = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_slot_stb = 1'b0;
  logic [15:0] i_mem_dout = '0;
  logic [20:0] o_mem_addr;
  logic [7:0]  o_mem_din;
  logic        o_mem_we, o_mem_aux;
  logic        i_cpu_req = 0, i_cpu_we = 0, i_cpu_aux = 0;
  logic [20:0] i_cpu_addr = '0;
  logic [7:0]  i_cpu_din = '0;
  logic        o_cpu_ack;
  logic [7:0]  o_cpu_dout;
  logic        i_tst_req = 0, i_tst_we = 0, i_tst_aux = 0;
  logic [20:0] i_tst_addr = '0;
  logic [7:0]  i_tst_din = '0;
  logic        o_tst_ack;
  logic [7:0]  o_tst_dout;
  logic        o_busy, o_err;

  sdram_port_arbiter #(.RD_DELAY(RD), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .i_slot_stb(i_slot_stb), .i_mem_dout(i_mem_dout),
    .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din), .o_mem_we(o_mem_we), .o_mem_aux(o_mem_aux),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_din(i_cpu_din),
    .i_cpu_aux(i_cpu_aux), .o_cpu_ack(o_cpu_ack), .o_cpu_dout(o_cpu_dout),
    .i_tst_req(i_tst_req), .i_tst_we(i_tst_we), .i_tst_addr(i_tst_addr), .i_tst_din(i_tst_din),
    .i_tst_aux(i_tst_aux), .o_tst_ack(o_tst_ack), .o_tst_dout(o_tst_dout),
    .o_busy(o_busy), .o_err(o_err));

  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        tst;
    logic [7:0]  cdout;
    logic [7:0]  tdout;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  m_cdout = '0;
  logic [7:0]  m_tdout = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Slot pulse sampled on one edge; returns that edge's cycle number.
  task automatic slot(output logic [31:0] n);
    i_slot_stb = 1'b1;
    @(posedge clk); #1;
    i_slot_stb = 1'b0;
    n = cyc;
  endtask

  task automatic exp_ack(input logic tst, input logic we, input logic [7:0] b, input logic [31:0] n);
    exp_t e;
    if (!we) begin
      if (tst) m_tdout = b; else m_cdout = b;
    end
    e.tst = tst; e.cdout = m_cdout; e.tdout = m_tdout; e.cyc = n + RD - 1;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && (o_cpu_ack || o_tst_ack)) begin
      chk("ack_exclusive", 64'(o_cpu_ack & o_tst_ack), 64'd0);
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ack cpu=%0b tst=%0b expected=none cyc=%0d", o_cpu_ack, o_tst_ack, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port_tst", 64'(o_tst_ack), 64'(e.tst));
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("cpu_dout", 64'(o_cpu_dout), 64'(e.cdout));
        chk("tst_dout", 64'(o_tst_dout), 64'(e.tdout));
        chk("we_low_on_ack", 64'(o_mem_we), 64'd0);
      end
    end
  end

  logic [31:0] n, n2;
  logic [5:0]  win;

  initial begin
    // reset state
    wait_cyc(3);
    chk("reset_outputs", 64'({o_mem_addr, o_mem_din, o_mem_we, o_mem_aux, o_cpu_ack, o_tst_ack,
                              o_cpu_dout, o_tst_dout, o_busy, o_err}), 64'd0);
    reset = 1'b0;
    wait_cyc(2);

    // CPU read, high byte
    i_mem_dout = 16'hA55A;
    i_cpu_req = 1; i_cpu_we = 0; i_cpu_addr = 21'h012345; i_cpu_aux = 1;
    slot(n);
    chk("cpu_rd_addr", 64'(o_mem_addr), 64'h012345);
    chk("cpu_rd_we", 64'(o_mem_we), 64'd0);
    chk("cpu_rd_busy", 64'(o_busy), 64'd1);
    exp_ack(0, 0, 8'hA5, n);
    wait_cyc(RD);
    i_cpu_req = 0;
    wait_cyc(4);

    // Tester write, low lane
    i_tst_req = 1; i_tst_we = 1; i_tst_din = 8'h3C; i_tst_aux = 0; i_tst_addr = 21'h1ABCDE;
    slot(n);
    chk("tst_wr_we", 64'(o_mem_we), 64'd1);
    chk("tst_wr_din", 64'(o_mem_din), 64'h3C);
    chk("tst_wr_addr", 64'(o_mem_addr), 64'h1ABCDE);
    exp_ack(1, 1, 8'h00, n);
    wait_cyc(RD);
    i_tst_req = 0; i_tst_we = 0;
    wait_cyc(4);

    // Idle slot
    slot(n);
    chk("idle_we", 64'(o_mem_we), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("idle_addr_hold", 64'(o_mem_addr), 64'h1ABCDE);
    wait_cyc(13);

    // Starvation: both held for 6 slots; tester wins only slot 5
    i_mem_dout = 16'h1234;
    i_cpu_req = 1; i_cpu_we = 0; i_cpu_addr = 21'h000AAA; i_cpu_aux = 0;
    i_tst_req = 1; i_tst_we = 0; i_tst_addr = 21'h000BBB; i_tst_aux = 1;
    win = 6'b010000;
    for (int s = 0; s < 6; s++) begin
      slot(n);
      chk("starve_grant_addr", 64'(o_mem_addr), win[s] ? 64'h000BBB : 64'h000AAA);
      exp_ack(win[s], 0, win[s] ? 8'h12 : 8'h34, n);
      if (s != 5) wait_cyc(13);
    end
    wait_cyc(RD);
    i_cpu_req = 0; i_tst_req = 0;
    wait_cyc(4);

    // Violation: extra slot while busy
    i_cpu_req = 1; i_cpu_addr = 21'h0C0C0C; i_cpu_aux = 1;
    slot(n);
    chk("viol_err_before", 64'(o_err), 64'd0);
    exp_ack(0, 0, 8'h12, n);
    wait_cyc(4);
    i_tst_req = 1; i_tst_addr = 21'h0DDDDD;
    slot(n2);
    chk("viol_slot_offset", 64'(n2 - n), 64'd5);
    chk("viol_err", 64'(o_err), 64'd1);
    chk("viol_no_regrant", 64'(o_mem_addr), 64'h0C0C0C);
    chk("viol_busy", 64'(o_busy), 64'd1);
    i_tst_req = 0;
    wait_cyc(5);
    i_cpu_req = 0;
    wait_cyc(4);

    // Reset mid-transfer aborts; pending request wins next slot
    i_mem_dout = 16'hBEEF;
    i_cpu_req = 1; i_cpu_addr = 21'h155555; i_cpu_aux = 0;
    slot(n);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    chk("midreset_outputs", 64'({o_mem_addr, o_mem_din, o_mem_we, o_mem_aux, o_cpu_ack, o_tst_ack,
                                 o_cpu_dout, o_tst_dout, o_busy, o_err}), 64'd0);
    m_cdout = '0; m_tdout = '0;
    reset = 1'b0;
    wait_cyc(8);
    slot(n);
    chk("post_reset_addr", 64'(o_mem_addr), 64'h155555);
    chk("post_reset_busy", 64'(o_busy), 64'd1);
    exp_ack(0, 0, 8'hEF, n);
    wait_cyc(RD);
    i_cpu_req = 0;
    wait_cyc(10);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 The block SHALL have parameter RD_DELAY, default 10, giving clk cycles from slot_stb to read-data capture and ack (legal 2..13).
REQ-002 The block SHALL have parameter MAX_WAIT, default 4, giving slots a pending tester request may lose before it is forced to win (legal 1..15).
REQ-003 clk  in  1  system clock, same clock as the SDRAM controller (up to 128 MHz); reset is reset, synchronous, active-high; clock is clk.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 slot_stb  in  1  one-clk pulse per 14-clk memory cycle; mem_* must be valid from the next clk for the whole slot.
REQ-006 mem_dout  in  16  read data from the SDRAM controller.
REQ-007 mem_addr  out  21  byte address to the controller; mem_din  out  8; mem_we  out  1; mem_aux  out  1 (byte lane select).
REQ-008 cpu_req  in  1; cpu_we  in  1; cpu_addr  in  21; cpu_din  in  8; cpu_aux  in  1; cpu_ack  out  1; cpu_dout  out  8: CPU port.
REQ-009 tst_req  in  1; tst_we  in  1; tst_addr  in  21; tst_din  in  8; tst_aux  in  1; tst_ack  out  1; tst_dout  out  8: tester port.
REQ-010 busy  out  1  a granted transfer is in flight; err  out  1  sticky protocol-violation flag.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 Requests SHALL be level: requester raises req with stable we/addr/din/aux and holds them until its ack; ack is a one-clk pulse.
REQ-013 req still high on the clk after ack SHALL be treated as a new request.
REQ-014 Arbitration SHALL occur only on a clk with slot_stb=1 and busy=0; req values at other times are ignored.
REQ-015 Priority: CPU wins, except when tst_req=1 and wait counter == MAX_WAIT, then tester wins.
REQ-016 Wait counter (4 bit): on each arbitration slot with tst_req=1 and tester not granted, increment, saturating at MAX_WAIT; cleared when tester granted or tst_req=0 at a slot_stb.
REQ-017 On grant the winner's addr/din/aux/we SHALL be latched into mem_addr/mem_din/mem_aux/mem_we on the clk after slot_stb and held until the next grant; busy goes 1 on the same clk.
REQ-018 On slot_stb with no request: mem_we SHALL be 0, mem_addr/mem_din/mem_aux hold previous values, busy stays 0, no ack.
REQ-019 A delay counter SHALL start at grant; exactly RD_DELAY clk after the slot_stb clk, the owner's ack pulses and busy returns to 0.
REQ-020 Reads: on the ack clk the owner's dout SHALL load mem_dout[15:8] when mem_aux=1, mem_dout[7:0] when mem_aux=0, sampled on the clk before the ack clk; the non-owner dout is unchanged.
REQ-021 Writes: ack timing identical to reads; dout unchanged.
REQ-022 mem_we SHALL drop to 0 on the ack clk so a granted write is never repeated in the next slot.
REQ-023 slot_stb while busy=1 SHALL be ignored for arbitration and SHALL set err=1; err clears only on reset.
REQ-024 cpu_ack and tst_ack SHALL never be 1 on the same clk.

Reset
REQ-025 While reset=1 the block SHALL drive mem_addr=0, mem_din=0, mem_we=0, mem_aux=0, cpu_ack=0, tst_ack=0, cpu_dout=0, tst_dout=0, busy=0, err=0, wait counter=0, delay counter=0.
REQ-026 Reset during a transfer SHALL abort it with no ack; the first slot_stb after reset release SHALL arbitrate normally.

Verification
REQ-027 CPU read: cpu_req=1, cpu_addr=0x012345, cpu_aux=1, mem_dout=0xA55A, slot_stb at T -> mem_addr=0x012345, mem_we=0 at T+1; cpu_ack at T+10; cpu_dout=0xA5.
REQ-028 Tester write: tst_req=1, tst_we=1, tst_din=0x3C, tst_aux=0, slot_stb at T -> mem_we=1, mem_din=0x3C at T+1; tst_ack at T+10; mem_we=0 at T+10.
REQ-029 Starvation: cpu_req and tst_req held high for 6 slots -> CPU granted slots 1-4, tester slot 5, CPU slot 6; never both acks on one clk.
REQ-030 Idle slot: no req, slot_stb -> mem_we=0, busy=0, no ack, mem_addr unchanged.
REQ-031 Violation: grant at T, extra slot_stb at T+5 -> err=1, no new grant, original ack still at T+10.
REQ-032 Reset mid-op: grant at T, reset at T+4..T+5 -> no ack, all outputs 0; next slot_stb grants pending request.
